// File: rtl/ddc_pkg.sv
// Shared types and constants for the DDC MAC arbiter slice.
package ddc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int NREQ_MIN = 2;
   localparam int NREQ_MAX = 8;

   // Round-robin successor of a channel index, wrapping n-1 back to 0.
   function automatic int wrap_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ddc_rr_pick.sv
// Combinational round-robin selector: first pending channel at or after ptr.
module ddc_rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] pending,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] winner,
   output logic [IW-1:0]   winner_idx
);

   int            sum;
   logic [IW-1:0] cand;

   // Scan from the farthest offset down so the closest pending channel to ptr wins.
   always_comb begin
      winner     = '0;
      winner_idx = '0;
      sum        = 0;
      cand       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = int'(ptr) + k;
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         cand = IW'(sum);
         if (pending[cand]) begin
            winner       = '0;
            winner[cand] = 1'b1;
            winner_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ddc_mac_arbiter.sv
// Round-robin arbiter sharing one MAC among NREQ filter channels.
// Optional sticky overrun flags are built when DDC_ARB_OVERRUN_EN is defined.
module ddc_mac_arbiter
   import ddc_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int OP_CYCLES = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [NREQ-1:0]              req,
   input  logic                         ovr_clr,
   output logic [NREQ-1:0]              grant,
   output logic                         start,
   output logic [$clog2(OP_CYCLES)-1:0] op_idx,
   output logic                         mac_last,
   output logic [NREQ-1:0]              done,
   output logic                         busy,
   output logic [NREQ-1:0]              overrun
);

   localparam int              OW       = $clog2(OP_CYCLES);
   localparam int              IW       = $clog2(NREQ);
   localparam logic [OW-1:0]   LAST_IDX = OW'(OP_CYCLES - 1);

   if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("ddc_mac_arbiter: NREQ out of range 2..8");
   end
   if (OP_CYCLES < 2 || OP_CYCLES > 256) begin : g_bad_ops
      $error("ddc_mac_arbiter: OP_CYCLES out of range 2..256");
   end

   state_t          state;
   logic [NREQ-1:0] pending;
   logic [NREQ-1:0] pick;
   logic [NREQ-1:0] take;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   pick_idx;
   logic            start_q;
   logic            at_last;
   logic            launch;

   ddc_rr_pick #(
      .NREQ(NREQ),
      .IW  (IW)
   ) u_pick (
      .pending   (pending),
      .ptr       (ptr),
      .winner    (pick),
      .winner_idx(pick_idx)
   );

   // A new job launches from IDLE or straight out of the last tap, so jobs chain without gaps.
   assign at_last = (state == RUN) && (op_idx == LAST_IDX);
   assign launch  = (|pending) && ((state == IDLE) || at_last);
   assign take    = launch ? pick : '0;

   // Pending bits use set-wins so a sample arriving on the grant edge is not lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
         grant   <= '0;
         op_idx  <= '0;
         ptr     <= '0;
         start_q <= 1'b0;
      end else if (en) begin
         pending <= (pending & ~take) | req;
         start_q <= 1'b0;
         if (launch) begin
            state   <= RUN;
            grant   <= pick;
            op_idx  <= '0;
            ptr     <= IW'(wrap_next(int'(pick_idx), NREQ));
            start_q <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  grant  <= '0;
                  op_idx <= '0;
               end
               RUN: begin
                  if (at_last) begin
                     state  <= IDLE;
                     grant  <= '0;
                     op_idx <= '0;
                  end else begin
                     op_idx <= op_idx + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign busy     = (state == RUN);
   assign start    = start_q & en & rst_n;
   assign mac_last = at_last & en & rst_n;
   assign done     = grant & {NREQ{mac_last}};

`ifdef DDC_ARB_OVERRUN_EN
   // A sample is lost only if its predecessor is still waiting and not being taken this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun <= '0;
      end else if (en) begin
         if (ovr_clr) begin
            overrun <= '0;
         end else begin
            overrun <= overrun | (req & pending & ~take);
         end
      end
   end
`else
   logic unused_ovr_clr;
   assign unused_ovr_clr = ovr_clr;
   assign overrun        = '0;
`endif

endmodule
